link_tx_ctrl: RTL and testbench

Go-back-N link transmit controller sitting directly downstream of the replay FIFO. It pops frames from the FIFO, tags each with a sequence number, and presents them on a valid/ready link port. It tracks cumulative acknowledgements from the link receiver. When every frame read since the last commit has been acknowledged, it commits them with a FIFO ACK pulse. On a receiver NAK (or timeout) it rewinds the FIFO with a NAK pulse and retransmits from the last commit point.

---
 rtl/link_tx_pkg.sv | 22 ++
 rtl/link_tx_timer.sv | 53 +++++
 rtl/link_tx_ctrl.sv | 178 +++++++++++++++++
 tb/tb_link_tx_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_tx_pkg.sv
// ---------------------------------------------------------------------------
// link_tx_pkg
// Shared types and constants for the go-back-N link transmit controller.
//   SEQ_WIDTH_DEF : default sequence number width
//   CNT_WIDTH     : width of the per-commit frame counters (one bit wider than
//                   a sequence number so a full window can be counted)
//   seq_t         : sequence number type at the default width
//   state_e       : controller state (RUN, REWIND)
// ---------------------------------------------------------------------------
package link_tx_pkg;

    localparam int SEQ_WIDTH_DEF = 4;
    localparam int CNT_WIDTH     = SEQ_WIDTH_DEF + 1;

    typedef logic [SEQ_WIDTH_DEF-1:0] seq_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        REWIND = 1'b1
    } state_e;

endpackage

// File: rtl/link_tx_timer.sv
// ---------------------------------------------------------------------------
// link_tx_timer
// Ack-progress watchdog for link_tx_ctrl. Counts the cycles in which it is
// told to run and raises expire on the (TIMEOUT-1)th such cycle since the
// last clear. The counter holds while run is low.
// Only instantiated when LINK_TX_TIMEOUT_EN is defined.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   run    in  count this cycle
//   clear  in  restart the count (ack progress, NAK, commit)
//   expire out combinational timeout strobe
// ---------------------------------------------------------------------------
module link_tx_timer
    import link_tx_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    // The counter only ever has to hold 0 .. TIMEOUT-2.
    localparam int            TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 2);

    logic [TW-1:0] cnt_q, cnt_d;

    // cnt_q counts the running cycles already completed, so the current cycle
    // is the (TIMEOUT-1)th one when cnt_q has reached TIMEOUT-2.
    assign expire = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/link_tx_ctrl.sv
// ---------------------------------------------------------------------------
// link_tx_ctrl
// Go-back-N link transmit controller placed directly after the replay FIFO.
// Pops frames, tags them with sequence numbers and presents them on a
// valid/ready link port. Cumulative receiver acks are tracked; once every
// frame read since the last commit is acknowledged the FIFO is committed with
// fifo_ack_o. A receiver NAK (or, optionally, a timeout) rewinds the FIFO with
// fifo_nak_o and transmission restarts from the last commit point.
//
// Optional feature: define LINK_TX_TIMEOUT_EN to enable a self-initiated
// replay after TIMEOUT-1 cycles without ack progress.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fifo_empty_i     FIFO empty flag
//   fifo_rdata_i     FIFO head data
//   fifo_rden_o      pop FIFO head (combinational)
//   fifo_ack_o       commit pulse to FIFO (combinational)
//   fifo_nak_o       rewind pulse to FIFO (combinational)
//   tx_valid_o       link frame valid (registered)
//   tx_ready_i       link accepts frame
//   tx_data_o        frame payload (registered)
//   tx_seq_o         frame sequence number (registered)
//   rx_ack_valid_i   cumulative ack strobe
//   rx_ack_seq_i     newest in-order sequence number accepted by receiver
//   rx_nak_valid_i   replay request strobe
//   outstanding_o    frames read since the last commit
// ---------------------------------------------------------------------------
module link_tx_ctrl
    import link_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_WIDTH  = SEQ_WIDTH_DEF,
    parameter int WINDOW     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rden_o,
    output logic                  fifo_ack_o,
    output logic                  fifo_nak_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic [SEQ_WIDTH-1:0]  tx_seq_o,
    input  logic                  rx_ack_valid_i,
    input  logic [SEQ_WIDTH-1:0]  rx_ack_seq_i,
    input  logic                  rx_nak_valid_i,
    output logic [SEQ_WIDTH:0]    outstanding_o
);

    localparam int            CW       = SEQ_WIDTH + 1;
    localparam logic [CW-1:0] WINDOW_C = CW'(WINDOW);

    state_e                state_q, state_d;
    logic [SEQ_WIDTH-1:0]  base_seq_q, base_seq_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         sent_cnt_q, sent_cnt_d;
    logic [CW-1:0]         ack_cnt_q, ack_cnt_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [SEQ_WIDTH-1:0]  tx_seq_q, tx_seq_d;

    logic                  timeout_nak;
    logic                  nak;
    logic                  handshake;
    logic                  ack_ok;
    logic                  commit;
    logic                  read;
    logic [SEQ_WIDTH-1:0]  ack_dist;
    logic [CW-1:0]         ack_dist_w;
    logic [CW-1:0]         ack_cnt_upd;

`ifdef LINK_TX_TIMEOUT_EN
    logic timer_run;
    logic timer_clear;

    // Only wait for acks while some accepted frame is still unacknowledged.
    assign timer_run   = (state_q == RUN) && (sent_cnt_q > ack_cnt_q);
    assign timer_clear = ack_ok | rx_nak_valid_i | commit;

    link_tx_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (timer_run),
        .clear  (timer_clear),
        .expire (timeout_nak)
    );
`else
    logic unused_timeout_cfg;

    assign timeout_nak        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    // Event decode with priority NAK > commit > read. The ack distance is the
    // number of frames covered by the cumulative ack, counted from base_seq.
    // Commit looks at the post-ack count so an ack can commit in its own cycle.
    always_comb begin
        handshake   = tx_valid_q & tx_ready_i;
        nak         = rx_nak_valid_i | timeout_nak;
        ack_dist    = rx_ack_seq_i - base_seq_q + SEQ_WIDTH'(1);
        ack_dist_w  = {1'b0, ack_dist};
        ack_ok      = (state_q == RUN) && !nak && rx_ack_valid_i &&
                      (ack_dist_w > ack_cnt_q) && (ack_dist_w <= sent_cnt_q);
        ack_cnt_upd = ack_ok ? ack_dist_w : ack_cnt_q;
        commit      = (state_q == RUN) && !nak &&
                      (ack_cnt_upd == rd_cnt_q) && (rd_cnt_q != '0);
        read        = (state_q == RUN) && !nak && !commit && !fifo_empty_i &&
                      (rd_cnt_q < WINDOW_C) && (!tx_valid_q || tx_ready_i);
    end

    // Next-state computation. A frame handshaking in a NAK cycle was sent on
    // the wire, but its count is discarded along with everything since the
    // last commit because the replay will send it again.
    always_comb begin
        state_d    = nak ? REWIND : RUN;
        base_seq_d = base_seq_q;
        rd_cnt_d   = rd_cnt_q;
        sent_cnt_d = sent_cnt_q + CW'(handshake);
        ack_cnt_d  = ack_cnt_upd;
        tx_valid_d = tx_valid_q & ~tx_ready_i;
        tx_data_d  = tx_data_q;
        tx_seq_d   = tx_seq_q;

        if (nak) begin
            rd_cnt_d   = '0;
            sent_cnt_d = '0;
            ack_cnt_d  = '0;
            tx_valid_d = 1'b0;
        end else if (commit) begin
            base_seq_d = base_seq_q + rd_cnt_q[SEQ_WIDTH-1:0];
            rd_cnt_d   = '0;
            sent_cnt_d = '0;
            ack_cnt_d  = '0;
        end else if (read) begin
            rd_cnt_d   = rd_cnt_q + CW'(1);
            tx_valid_d = 1'b1;
            tx_data_d  = fifo_rdata_i;
            tx_seq_d   = base_seq_q + rd_cnt_q[SEQ_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            base_seq_q <= '0;
            rd_cnt_q   <= '0;
            sent_cnt_q <= '0;
            ack_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_seq_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_seq_q <= base_seq_d;
            rd_cnt_q   <= rd_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_seq_q   <= tx_seq_d;
        end
    end

    assign fifo_rden_o   = read;
    assign fifo_ack_o    = commit;
    assign fifo_nak_o    = nak;
    assign tx_valid_o    = tx_valid_q;
    assign tx_data_o     = tx_data_q;
    assign tx_seq_o      = tx_seq_q;
    assign outstanding_o = rd_cnt_q;

endmodule

// File: tb/tb_link_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_link_tx_ctrl
// Bench for link_tx_ctrl with a behavioural replay FIFO. Every frame written
// to the FIFO is pushed to an expected queue with the sequence number it must
// carry; frames accepted on the link are popped and compared. Frames accepted
// since the last commit are kept aside so a rewind can put them back in front.
// ---------------------------------------------------------------------------
module tb_link_tx_ctrl;
    import link_tx_pkg::*;

    localparam int DW  = 32;
    localparam int SW  = SEQ_WIDTH_DEF;
    localparam int WIN = 8;
    localparam int TO  = 16;

    typedef logic [SW+DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rden;
    logic          fifo_ack;
    logic          fifo_nak;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] tx_data;
    seq_t          tx_seq;
    logic          rx_ack_valid = 1'b0;
    seq_t          rx_ack_seq = '0;
    logic          rx_nak_valid = 1'b0;
    logic [SW:0]   outstanding;

    always #5 clk = ~clk;

    link_tx_ctrl #(
        .DATA_WIDTH (DW),
        .SEQ_WIDTH  (SW),
        .WINDOW     (WIN),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty_i   (fifo_empty),
        .fifo_rdata_i   (fifo_rdata),
        .fifo_rden_o    (fifo_rden),
        .fifo_ack_o     (fifo_ack),
        .fifo_nak_o     (fifo_nak),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .tx_data_o      (tx_data),
        .tx_seq_o       (tx_seq),
        .rx_ack_valid_i (rx_ack_valid),
        .rx_ack_seq_i   (rx_ack_seq),
        .rx_nak_valid_i (rx_nak_valid),
        .outstanding_o  (outstanding)
    );

    // Behavioural replay FIFO: read pointer, commit pointer, write pointer.
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cmt_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = mem[rd_ptr[7:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= 0;
            cmt_ptr <= 0;
        end else if (fifo_nak) begin
            rd_ptr <= cmt_ptr;
        end else begin
            if (fifo_ack) cmt_ptr <= rd_ptr;
            if (fifo_rden) rd_ptr <= rd_ptr + 1;
        end
    end

    frame_t exp_q[$];
    frame_t infl_q[$];
    seq_t   next_seq;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_total = 0;
    int rden_total = 0;
    int ack_total = 0;
    int nak_total = 0;
    int last_hs_cyc = 0;
    int last_nak_cyc = 0;
    logic mon_rden = 1'b0;
    logic mon_nak = 1'b0;

    // The single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe mid-cycle, then step to just after the edge.
    task automatic tick();
        frame_t f;
        @(negedge clk);
        if (rst_n) begin
            mon_rden = fifo_rden;
            mon_nak  = fifo_nak;
            if (fifo_rden) rden_total++;
            if (fifo_ack) begin
                ack_total++;
                infl_q.delete();
            end
            if (tx_valid && tx_ready) begin
                hs_total++;
                last_hs_cyc = cyc;
                f = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checkOutput("sb_frame", {tx_seq, tx_data}, f);
                infl_q.push_back(f);
            end
            if (fifo_nak) begin
                nak_total++;
                last_nak_cyc = cyc;
                for (int i = infl_q.size() - 1; i >= 0; i--) exp_q.push_front(infl_q[i]);
                infl_q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Write one frame into the FIFO and record the frame the link must see.
    task automatic applyStimulus(input logic [DW-1:0] data);
        mem[wr_ptr[7:0]] = data;
        wr_ptr++;
        exp_q.push_back({next_seq, data});
        next_seq++;
    endtask

    task automatic sendAck(input seq_t s);
        rx_ack_valid = 1'b1;
        rx_ack_seq   = s;
        tick();
        rx_ack_valid = 1'b0;
    endtask

    task automatic sendNak();
        rx_nak_valid = 1'b1;
        tick();
        rx_nak_valid = 1'b0;
    endtask

    task automatic waitHs(input int target, input int budget, input string tag);
        int n = 0;
        while (hs_total < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, hs_total, target);
    endtask

    task automatic waitNak(input int target, input int budget, input string tag);
        int n = 0;
        while (nak_total < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, nak_total, target);
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        tx_ready     = 1'b0;
        rx_ack_valid = 1'b0;
        rx_nak_valid = 1'b0;
        #1;
        checkOutput("rst_valid", tx_valid, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        wr_ptr   = 0;
        next_seq = '0;
        exp_q.delete();
        infl_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int h0, r0, a0, n0, c0, hsc;

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_seq", tx_seq, 0);
        checkOutput("rst_data", tx_data, 0);
        checkOutput("rst_rden", fifo_rden, 0);
        checkOutput("rst_ack", fifo_ack, 0);
        checkOutput("rst_nak", fifo_nak, 0);

        // Streaming four frames back to back, then a full cumulative ack
        tx_ready = 1'b1;
        h0 = hs_total; r0 = rden_total; a0 = ack_total; c0 = cyc;
        for (int i = 0; i < 4; i++) applyStimulus(32'hA0 + i);
        waitHs(h0 + 4, 20, "stream_hs");
        checkOutput("stream_last_hs_cycle", last_hs_cyc - c0, 4);
        checkOutput("stream_rden", rden_total - r0, 4);
        sendAck(3);
        checkOutput("stream_commit", ack_total - a0, 1);
        checkOutput("stream_outstanding", outstanding, 0);
        applyStimulus(32'hA4);
        waitHs(h0 + 5, 10, "stream_base4_hs");
        sendAck(4);
        checkOutput("stream_commit2", ack_total - a0, 2);

        // Window limit with twelve queued frames
        doReset();
        tx_ready = 1'b1;
        h0 = hs_total; r0 = rden_total; a0 = ack_total;
        for (int i = 0; i < 12; i++) applyStimulus(32'hB0 + i);
        repeat (12) tick();
        checkOutput("win_rden", rden_total - r0, WIN);
        checkOutput("win_hs", hs_total - h0, WIN);
        checkOutput("win_valid_low", tx_valid, 0);
        checkOutput("win_outstanding", outstanding, WIN);
        sendAck(7);
        checkOutput("win_commit", ack_total - a0, 1);
        waitHs(h0 + 12, 20, "win_rest_hs");
        checkOutput("win_rden_all", rden_total - r0, 12);
        sendAck(11);
        checkOutput("win_commit2", ack_total - a0, 2);
        checkOutput("win_outstanding_end", outstanding, 0);

        // Partial, stale and out-of-range acks
        doReset();
        tx_ready = 1'b1;
        h0 = hs_total; a0 = ack_total;
        for (int i = 0; i < 4; i++) applyStimulus(32'hC0 + i);
        waitHs(h0 + 4, 20, "part_hs");
        sendAck(1);
        checkOutput("part_no_commit", ack_total - a0, 0);
        checkOutput("part_outstanding", outstanding, 4);
        sendAck(0);
        sendAck(5);
        checkOutput("part_stale_ignored", ack_total - a0, 0);
        sendAck(3);
        checkOutput("part_commit", ack_total - a0, 1);

        // NAK replay from the commit point
        doReset();
        tx_ready = 1'b1;
        h0 = hs_total; a0 = ack_total; n0 = nak_total;
        for (int i = 0; i < 4; i++) applyStimulus(32'hD0 + i);
        waitHs(h0 + 4, 20, "nak_hs");
        sendAck(1);
        checkOutput("nak_pre_commit", ack_total - a0, 0);
        sendNak();
        checkOutput("nak_pulse", mon_nak, 1);
        checkOutput("nak_cycle_rden", mon_rden, 0);
        tick();
        checkOutput("rewind_rden", mon_rden, 0);
        checkOutput("rewind_outstanding", outstanding, 0);
        tick();
        checkOutput("replay_read", mon_rden, 1);
        checkOutput("replay_valid", tx_valid, 1);
        checkOutput("replay_seq", tx_seq, 0);
        waitHs(h0 + 8, 20, "replay_hs");
        sendAck(3);
        checkOutput("replay_commit", ack_total - a0, 1);
        checkOutput("nak_count", nak_total - n0, 1);

        // NAK and ack together while a handshake is pending
        doReset();
        tx_ready = 1'b1;
        h0 = hs_total; a0 = ack_total; n0 = nak_total;
        for (int i = 0; i < 4; i++) applyStimulus(32'hE0 + i);
        waitHs(h0 + 1, 10, "both_first_hs");
        checkOutput("both_pre_valid", tx_valid, 1);
        rx_nak_valid = 1'b1;
        rx_ack_valid = 1'b1;
        rx_ack_seq   = '0;
        tick();
        rx_nak_valid = 1'b0;
        rx_ack_valid = 1'b0;
        checkOutput("both_nak", mon_nak, 1);
        checkOutput("both_valid_low", tx_valid, 0);
        checkOutput("both_outstanding", outstanding, 0);
        checkOutput("both_no_commit", ack_total - a0, 0);
        waitHs(h0 + 6, 20, "both_replay_hs");
        sendAck(3);
        checkOutput("both_commit", ack_total - a0, 1);

`ifdef LINK_TX_TIMEOUT_EN
        // Self-initiated replay after TIMEOUT-1 cycles without ack progress
        doReset();
        tx_ready = 1'b1;
        h0 = hs_total; a0 = ack_total; n0 = nak_total;
        applyStimulus(32'hF0);
        waitHs(h0 + 1, 10, "to_hs");
        hsc = last_hs_cyc;
        waitNak(n0 + 1, 40, "to_nak");
        checkOutput("to_delay", last_nak_cyc - hsc, TO - 1);
        waitHs(h0 + 2, 10, "to_resend_hs");
        sendAck(0);
        checkOutput("to_commit", ack_total - a0, 1);
`endif

        checkOutput("sb_drained", exp_q.size(), 0);

        // Reset asserted while frames are streaming
        doReset();
        tx_ready = 1'b1;
        h0 = hs_total;
        for (int i = 0; i < 4; i++) applyStimulus(32'h50 + i);
        waitHs(h0 + 2, 10, "mid_hs");
        doReset();
        tick();
        checkOutput("mid_after_valid", tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
